load_store_unit: RTL and testbench

//  Initiator side of the data-memory port. Takes one load/store request at a time from the

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, byte/half/word loads and stores on a
// word-only memory, using read-modify-write for sub-word stores. Big-endian lanes.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              off_q, off_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cs_q, cs_d;
    logic                    mwe_q, mwe_d;
    logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d;

    logic                    req_bad;
    logic [4:0]              shamt;
    logic [DATA_WIDTH-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0]   lane;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merged;

    assign req_bad = (req_size == 2'b11)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    // Big-endian lane position: offset 0 is the most significant byte/half.
    always_comb begin
        shamt     = '0;
        lane_mask = '1;
        if (size_q == SZ_BYTE) begin
            shamt     = {2'd3 - off_q, 3'b000};
            lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
        end else if (size_q == SZ_HALF) begin
            shamt     = {~off_q[1], 4'b0000};
            lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
        end
    end

    always_comb begin
        lane     = mem_rdata >> shamt;
        load_val = mem_rdata;
        if (size_q == SZ_BYTE)
            load_val = {{(DATA_WIDTH-8){~uns_q & lane[7]}}, lane[7:0]};
        else if (size_q == SZ_HALF)
            load_val = {{(DATA_WIDTH-16){~uns_q & lane[15]}}, lane[15:0]};
        merged = (mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        addr_d   = addr_q;
        mwdata_d = mwdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d  = 1'b0;
                        addr_d = req_addr[ADDR_WIDTH+1:2];
                        if (req_we && req_size == SZ_WORD) begin
                            mwdata_d = req_wdata;
                            state_d  = WR_ISSUE;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (we_q) begin
                    mwdata_d = merged;
                    state_d  = WR_ISSUE;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR_ISSUE: state_d = RESP;
            RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake and memory strobes are registered copies of the next state.
        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == RESP);
        cs_d     = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
        mwe_d    = (state_d == WR_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            mwe_q    <= 1'b0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            mwe_q    <= mwe_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign req_ready   = ready_q;
    assign resp_valid  = rvalid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_address = addr_q;
    assign mem_cs      = cs_q;
    assign mem_we      = mwe_q;
    assign mem_wdata   = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: word-array memory model on the port side and a
// byte-array reference model computing expected results, latency and access counts.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [12:0] mem_address;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem   [0:8191];
    logic [7:0]  ref_b [0:32767];
    int cs_cnt = 0, we_cnt = 0, rv_cnt = 0, cyc = 0;
    int n_cmp = 0, n_mis = 0;

    always @(posedge clk) begin
        if (mem_cs && mem_we)  mem[mem_address] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= mem[mem_address];
    end

    always @(posedge clk) begin
        cyc++;
        if (mem_cs) cs_cnt++;
        if (mem_cs && mem_we) we_cnt++;
        if (resp_valid) rv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int unsigned baddr, input logic [31:0] w);
        mem[baddr >> 2] = w;
        for (int i = 0; i < 4; i++) ref_b[(baddr & ~32'd3) + i] = w[31-8*i -: 8];
    endtask

    function automatic logic [31:0] ref_word(input int unsigned waddr);
        return {ref_b[4*waddr], ref_b[4*waddr+1], ref_b[4*waddr+2], ref_b[4*waddr+3]};
    endfunction

    // Expected outcome from the access rules; stores update the byte array.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [14:0] addr, input logic [31:0] wdata,
                              output logic [31:0] er, output logic ee,
                              output int elat, output int encs, output int enwe);
        int unsigned a = addr;
        int unsigned nb = 1 << size;
        longint unsigned v = 0;
        if (size == 2'b11 || (a % nb) != 0) begin
            er = 0; ee = 1; elat = 1; encs = 0; enwe = 0;
        end else if (we) begin
            for (int unsigned i = 0; i < nb; i++)
                ref_b[a+i] = 8'((wdata >> (8*(nb-1-i))) & 32'hFF);
            er = 0; ee = 0; enwe = 1;
            elat = (nb == 4) ? 2 : 4;
            encs = (nb == 4) ? 1 : 2;
        end else begin
            for (int unsigned i = 0; i < nb; i++) v = (v << 8) | longint'(ref_b[a+i]);
            if (!uns && nb < 4 && ((v >> (8*nb-1)) & 1) == 1)
                v = v | ~((64'd1 << (8*nb)) - 1);
            er = v[31:0]; ee = 0; elat = 3; encs = 1; enwe = 0;
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [14:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int ncs, output int nwe);
        int cs0, we0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
        cs0 = cs_cnt; we0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 15'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata; err = resp_err;
        ncs = cs_cnt - cs0; nwe = we_cnt - we0;
    endtask

    task automatic run_check(input logic we, input logic [1:0] size, input logic uns,
                             input logic [14:0] addr, input logic [31:0] wdata,
                             output logic [31:0] got);
        logic [31:0] er; logic ee, ge;
        int el, ecs, ewe, gl, gcs, gwe;
        txn(we, size, uns, addr, wdata, got, ge, gl, gcs, gwe);
        ref_access(we, size, uns, addr, wdata, er, ee, el, ecs, ewe);
        check_eq("rdata", got, er);
        check_eq("err", {31'd0, ge}, {31'd0, ee});
        check_eq("latency", gl, el);
        check_eq("cs_pulses", gcs, ecs);
        check_eq("we_pulses", gwe, ewe);
    endtask

    logic [31:0] got;
    logic [14:0] a5 [3];
    logic [1:0]  s5 [3];
    logic        u5 [3];
    logic [31:0] e5 [3];
    int          acc [3];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 8192; i++) preload(4*i, $urandom);
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_cs_we", {30'd0, mem_cs, mem_we}, 32'd0);
        check_eq("rst_addr", {19'd0, mem_address}, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Word store then load
        run_check(1'b1, 2'b10, 1'b0, 15'h0010, 32'hDEADBEEF, got);
        check_eq("t1_mem", mem[4], 32'hDEADBEEF);
        run_check(1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, got);
        check_eq("t1_load", got, 32'hDEADBEEF);

        // Sub-word loads
        @(negedge clk); preload(32'h20, 32'h11A2B3C4);
        run_check(1'b0, 2'b00, 1'b0, 15'h0021, 32'h0, got);
        check_eq("t2_b1s", got, 32'hFFFFFFA2);
        run_check(1'b0, 2'b00, 1'b1, 15'h0023, 32'h0, got);
        check_eq("t2_b3u", got, 32'h000000C4);
        run_check(1'b0, 2'b01, 1'b0, 15'h0022, 32'h0, got);
        check_eq("t2_h2s", got, 32'hFFFFB3C4);

        // Byte store read-modify-write
        run_check(1'b1, 2'b00, 1'b0, 15'h0022, 32'hFFFFFF55, got);
        check_eq("t3_mem", mem[8], 32'h11A255C4);

        // Misaligned / illegal
        run_check(1'b0, 2'b10, 1'b0, 15'h0006, 32'h0, got);
        run_check(1'b1, 2'b01, 1'b0, 15'h0003, 32'h1234, got);
        run_check(1'b0, 2'b11, 1'b0, 15'h0008, 32'h0, got);

        // Back-to-back loads with req_valid held high
        begin
            logic ee; int el, ec, ew, idx, rcnt, busy, rv0, cs0;
            logic pend;
            a5[0] = 15'h0020; s5[0] = 2'b10; u5[0] = 1'b0;
            a5[1] = 15'h0010; s5[1] = 2'b00; u5[1] = 1'b1;
            a5[2] = 15'h0012; s5[2] = 2'b01; u5[2] = 1'b0;
            for (int i = 0; i < 3; i++)
                ref_access(1'b0, s5[i], u5[i], a5[i], 32'h0, e5[i], ee, el, ec, ew);
            idx = 0; rcnt = 0; busy = 0; pend = 1'b0;
            @(negedge clk);
            rv0 = rv_cnt; cs0 = cs_cnt;
            req_we = 1'b0; req_size = s5[0]; req_unsigned = u5[0]; req_addr = a5[0];
            req_valid = 1'b1;
            for (int t = 0; t < 40 && rcnt < 3; t++) begin
                if (resp_valid) begin
                    check_eq("b2b_rdata", resp_rdata, e5[rcnt]);
                    rcnt++;
                end
                if (req_valid && req_ready) begin
                    acc[idx] = cyc; pend = 1'b1;
                end else if (req_valid) begin
                    busy++;
                end
                @(negedge clk);
                if (pend) begin
                    pend = 1'b0; idx++;
                    if (idx < 3) begin
                        req_size = s5[idx]; req_unsigned = u5[idx]; req_addr = a5[idx];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            req_valid = 1'b0;
            check_eq("b2b_resps", rcnt, 3);
            check_eq("b2b_accepts", idx, 3);
            check_eq("b2b_gap01", acc[1] - acc[0], 4);
            check_eq("b2b_gap12", acc[2] - acc[1], 4);
            check_eq("b2b_busy", busy, 6);
            check_eq("b2b_rv_cnt", rv_cnt - rv0, 3);
            check_eq("b2b_cs_cnt", cs_cnt - cs0, 3);
        end

        // Random traffic over a small window for address reuse
        for (int n = 0; n < 200; n++)
            run_check(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                      15'($urandom_range(0, 127)), $urandom, got);
        for (int w = 0; w < 32; w++) check_eq("mem_word", mem[w], ref_word(w));

        // Reset during RD_WAIT of a byte store
        begin
            int we0, rv0;
            @(negedge clk); preload(32'h40, 32'hCAFEF00D);
            we0 = we_cnt; rv0 = rv_cnt;
            req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 15'h0041; req_wdata = 32'h99; req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk); req_valid = 1'b0;
            @(negedge clk); rst = 1'b1;
            @(negedge clk);
            check_eq("rst6_ready", {31'd0, req_ready}, 32'd1);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            check_eq("rst6_we", we_cnt - we0, 0);
            check_eq("rst6_rv", rv_cnt - rv0, 0);
            check_eq("rst6_mem", mem[16], 32'hCAFEF00D);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
